gdb_uart_fifo: RTL and testbench
================================

# gdb_uart_fifo

Serial front end for the hardware GDB remote-protocol target: an 8N1 UART transmitter and receiver plus an 8-bit receive FIFO. Every received byte is pushed into the FIFO automatically. The protocol engine drains the FIFO with a standard-mode (registered-output) read port and drives the transmitter byte by byte.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud); minimum 8.
- `FIFO_DEPTH`, default 16: receive FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  serial input; asynchronous; idle high.
- `tx`  out  1  serial output; idle high.
- `transmit`  in  1  one-cycle request to send `tx_byte`.
- `tx_byte`  in  8  byte to send; sampled when `transmit` is accepted.
- `is_transmitting`  out  1  transmitter busy.
- `is_receiving`  out  1  receiver inside a frame.
- `recv_error`  out  1  one-cycle pulse on a framing error.
- `rd_en`  in  1  FIFO read request.
- `dout`  out  8  FIFO read data (registered).
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- **Transmitter states:** IDLE, START, DATA, STOP.
  - IDLE: `transmit` high latches `tx_byte` and enters START. `transmit` outside IDLE is ignored; it is neither queued nor able to corrupt the frame in progress.
  - START drives `tx`=0, DATA drives each bit LSB first, STOP drives `tx`=1. Each state or bit lasts exactly `CLKS_PER_BIT` cycles.
  - `is_transmitting` is high in every state except IDLE.
- **Receiver:**
  - `rx` passes through a 2-flop synchronizer.
  - **States:** IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge (1 followed by 0) enters START.
  - START: after `CLKS_PER_BIT/2` cycles, rx=0 enters DATA; rx=1 is a glitch and returns to IDLE with no error.
  - DATA: samples each data bit `CLKS_PER_BIT` cycles after the previous sample, shifting in LSB first.
  - STOP: samples the stop bit at mid-bit. Stop=1 writes the byte into the FIFO that cycle. Stop=0 drops the byte and pulses `recv_error` for one cycle. Either outcome returns to IDLE.
  - `is_receiving` is high from START entry until the cycle the stop bit is sampled.
- **FIFO:** circular buffer with read/write pointers and an occupancy count of width log2(`FIFO_DEPTH`)+1.
  - Write (from the receiver) when full: the byte is dropped and the contents are unchanged.
  - Read: on an edge with `rd_en`=1 and `empty`=0, `dout` takes the oldest byte and the count decrements.
  - `rd_en` while empty is ignored; `dout` holds its value.
  - Simultaneous read and write when not empty: both occur and the count is unchanged.
  - Simultaneous read and write when empty: only the write occurs.
  - Simultaneous read and write when full: both occur; the read frees the slot.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `empty` = (count==0) and `full` = (count==`FIFO_DEPTH`), both registered or derived from the registered count. Neither has combinational paths from `rd_en`.

## Timing
- **Reset values:** `tx`=1, `is_transmitting`=0, `is_receiving`=0, `recv_error`=0, `dout`=0, `empty`=1, `full`=0. Pointers and count are 0 and both FSMs are IDLE.
- Reset mid-frame aborts immediately. The tx line returns high the next cycle, and a partial rx byte is discarded.
- **Transmit timing:**
  - `transmit` accepted at edge k: `tx`=0 and `is_transmitting`=1 from cycle k+1.
  - `is_transmitting` falls exactly 10×`CLKS_PER_BIT` cycles after k+1.
  - A new `transmit` is accepted in the first cycle `is_transmitting`=0, so back-to-back frames are gapless.
- **Receive latency:** the stop bit is sampled ≈9.5 bit periods plus 2 synchronizer cycles after the start edge. `empty` falls the cycle after that sample.
- **Read latency:** 1 cycle. `rd_en` sampled at edge n makes data valid on `dout` after edge n. `empty` updates after the same edge.

## Test plan
- Reset, then idle: `tx`=1, `empty`=1, `full`=0, `dout`=0, busy flags 0.
- Transmit, with `CLKS_PER_BIT`=16: `tx_byte`=0x2B and `transmit` pulse → `tx` shows 0,1,1,0,1,0,1,0,0,1, each level held 16 cycles. `is_transmitting` is high for 160 cycles. A second `transmit` mid-frame is ignored.
- Receive: serial "$g#67" at 16 clocks/bit → `empty` falls after the first frame. Five rd_en pulses yield `dout` 0x24, 0x67, 0x23, 0x36, 0x37, and `empty`=1 after the fifth.
- Framing and glitch: a frame with stop=0 gives a `recv_error` pulse and no FIFO write. A 3-cycle low glitch produces no byte and no error.
- FIFO boundaries: 17 frames received without reads → `full`=1 and byte 17 is dropped. 16 reads return bytes 1..16 in order. A 17th read leaves `dout` unchanged.
- Reset mid-frame during tx and rx → outputs return to reset values, and no byte appears in the FIFO.

Source files
------------

// File: rtl/gdb_uart_fifo_if.sv
// Serial, transmit and receive-FIFO signals of the GDB UART front end.
// The DUT side uses the slave modport and the protocol engine uses the master modport.
interface gdb_uart_fifo_if;
  logic       rx;
  logic       tx;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting;
  logic       is_receiving;
  logic       recv_error;
  logic       rd_en;
  logic [7:0] dout;
  logic       empty;
  logic       full;

  modport slave (
    input  rx, transmit, tx_byte, rd_en,
    output tx, is_transmitting, is_receiving, recv_error, dout, empty, full
  );

  modport master (
    output rx, transmit, tx_byte, rd_en,
    input  tx, is_transmitting, is_receiving, recv_error, dout, empty, full
  );
endinterface

// File: rtl/gdb_uart_fifo.sv
// 8N1 UART transmitter and receiver. Every received byte is pushed into a receive FIFO,
// which has a registered read port.
module gdb_uart_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input logic            clk,
  input logic            rst,
  gdb_uart_fifo_if.slave bus
);
  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (bus.transmit) begin
          tx_shift_d = bus.tx_byte;
          tx_state_d = TxStart;
          tx_d       = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
          tx_d       = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // ---------------- receiver ----------------
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            recv_error_q, recv_error_d;
  logic            wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      recv_error_q <= 1'b0;
    end else begin
      rx_s1_q      <= bus.rx;
      rx_s2_q      <= rx_s1_q;
      rx_s3_q      <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      recv_error_q <= recv_error_d;
    end
  end

  // rx_s2_q is the synchronized line; rx_s3_q is its previous value, used for edge detection.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CntW'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    recv_error_d = 1'b0;
    wr_en        = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d     = '0;
          rx_state_d   = RxIdle;
          wr_en        = rx_s2_q;
          recv_error_d = !rx_s2_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic [7:0]        dout_q;
  logic              fifo_empty, fifo_full, do_rd, do_wr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CountW'(FIFO_DEPTH));
  assign do_rd      = bus.rd_en && !fifo_empty;
  // A read in the same cycle frees a slot, so a write to a full FIFO can still land.
  assign do_wr      = wr_en && (!fifo_full || do_rd);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd)      count_d = count_q + CountW'(1);
    else if (do_rd && !do_wr) count_d = count_q - CountW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr) wptr_q <= wptr_q + PtrW'(1);
      if (do_rd) begin
        rptr_q <= rptr_q + PtrW'(1);
        dout_q <= mem_q[rptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= rx_shift_q;
  end

  assign bus.tx              = tx_q;
  assign bus.is_transmitting = (tx_state_q != TxIdle);
  assign bus.is_receiving    = (rx_state_q != RxIdle);
  assign bus.recv_error      = recv_error_q;
  assign bus.dout            = dout_q;
  assign bus.empty           = fifo_empty;
  assign bus.full            = fifo_full;
endmodule

// File: tb/tb_gdb_uart_fifo.sv
// Randomized bench for gdb_uart_fifo. A queue model of the FIFO and frame-level
// bit sequences supply the expected values.
`timescale 1ns/1ps
module tb_gdb_uart_fifo;
  localparam int Cpb   = 16;
  localparam int Depth = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gdb_uart_fifo_if u_if ();

  gdb_uart_fifo #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (Depth)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int         n_pass   = 0;
  int         n_checks = 0;
  int         err_cnt  = 0;
  int         exp_err  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_dout = 8'h00;

  always @(posedge clk) begin
    if (u_if.recv_error === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sends one byte. Entry and exit are at a negedge with the transmitter idle.
  task automatic send_tx(input logic [7:0] b, input bit inject);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    u_if.transmit = 1'b1;
    u_if.tx_byte  = b;
    @(negedge clk);
    u_if.transmit = 1'b0;
    u_if.tx_byte  = 8'($urandom);
    for (int i = 0; i < 10 * Cpb; i++) begin
      check("tx_line", u_if.tx, frame[i / Cpb]);
      if (i % Cpb == 0) check("tx_busy", u_if.is_transmitting, 1);
      u_if.transmit = inject && (i == 50);
      @(negedge clk);
    end
    u_if.transmit = 1'b0;
    check("tx_busy_end", u_if.is_transmitting, 0);
    check("tx_idle_line", u_if.tx, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      u_if.rx = frame[i];
      repeat (Cpb) @(negedge clk);
    end
    u_if.rx = 1'b1;
    repeat (6) @(negedge clk);
    if (stop && exp_q.size() < Depth) exp_q.push_back(b);
    if (!stop) exp_err++;
    check("rx_empty", u_if.empty, exp_q.size() == 0);
    check("rx_full", u_if.full, exp_q.size() == Depth);
    check("rx_err_cnt", err_cnt, exp_err);
    check("rx_idle", u_if.is_receiving, 0);
  endtask

  task automatic do_read();
    u_if.rd_en = 1'b1;
    @(negedge clk);
    u_if.rd_en = 1'b0;
    if (exp_q.size() > 0) last_dout = exp_q.pop_front();
    check("rd_dout", u_if.dout, last_dout);
    check("rd_empty", u_if.empty, exp_q.size() == 0);
    check("rd_full", u_if.full, exp_q.size() == Depth);
  endtask

  initial begin
    logic [7:0] msg [5];
    msg = '{8'h24, 8'h67, 8'h23, 8'h36, 8'h37};
    u_if.rx       = 1'b1;
    u_if.transmit = 1'b0;
    u_if.tx_byte  = 8'h00;
    u_if.rd_en    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", u_if.tx, 1);
    check("rst_empty", u_if.empty, 1);
    check("rst_full", u_if.full, 0);
    check("rst_dout", u_if.dout, 0);
    check("rst_is_tx", u_if.is_transmitting, 0);
    check("rst_is_rx", u_if.is_receiving, 0);
    check("rst_err", u_if.recv_error, 0);

    // Transmit 0x2B with a mid-frame request that must be ignored, then gapless frames.
    send_tx(8'h2B, 1'b1);
    for (int i = 0; i < 3; i++) send_tx(8'($urandom), 1'b0);

    // Receive "$g#67" and drain it.
    foreach (msg[i]) send_rx(msg[i], 1'b1);
    for (int i = 0; i < 5; i++) do_read();

    // Framing error, then a short low glitch.
    send_rx(8'($urandom), 1'b0);
    u_if.rx = 1'b0;
    repeat (3) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_empty", u_if.empty, 1);
    check("glitch_err", err_cnt, exp_err);

    // Overfill: 17 frames, 16 stored; 17 reads with the last holding dout.
    for (int i = 0; i < Depth + 1; i++) send_rx(8'($urandom), 1'b1);
    for (int i = 0; i < Depth + 1; i++) do_read();

    // Randomized mix of receive, read and transmit operations.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0, 1: send_rx(8'($urandom), logic'($urandom_range(0, 5) != 0));
        2: do_read();
        default: send_tx(8'($urandom), bit'($urandom_range(0, 1)));
      endcase
    end
    for (int i = 0; i < 3; i++) send_rx(8'($urandom), 1'b1);

    // Reset while both a transmit frame and a receive frame are in progress.
    u_if.transmit = 1'b1;
    u_if.tx_byte  = 8'hA5;
    u_if.rx       = 1'b0;
    @(negedge clk);
    u_if.transmit = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_busy", u_if.is_transmitting, 1);
    check("pre_rst_rx", u_if.is_receiving, 1);
    rst     = 1'b1;
    u_if.rx = 1'b1;
    @(negedge clk);
    exp_q.delete();
    last_dout = 8'h00;
    check("mid_rst_tx", u_if.tx, 1);
    check("mid_rst_is_tx", u_if.is_transmitting, 0);
    check("mid_rst_is_rx", u_if.is_receiving, 0);
    check("mid_rst_empty", u_if.empty, 1);
    check("mid_rst_full", u_if.full, 0);
    check("mid_rst_dout", u_if.dout, last_dout);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("post_rst_empty", u_if.empty, 1);
    check("post_rst_err", err_cnt, exp_err);
    check("post_rst_tx", u_if.tx, 1);
    send_rx(8'h5A, 1'b1);
    do_read();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
